// File: rtl/uart_rx_pkg.sv
// Shared types for the UART RX frame checker: parity-mode encodings, FSM
// states and the expected-parity-bit helper.
package uart_rx_pkg;

    // Runtime parity mode as presented on PAR_TYP.
    typedef enum logic [1:0] {
        PAR_EVEN  = 2'b00,
        PAR_ODD   = 2'b01,
        PAR_MARK  = 2'b10,
        PAR_SPACE = 2'b11
    } par_typ_e;

    // Frame-level FSM states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_DATA   = 2'b01,
        ST_PARITY = 2'b10,
        ST_STOP   = 2'b11
    } state_e;

    // Parity bit the transmitter should have sent, given the XOR of the data bits.
    function automatic logic expected_par_bit(input par_typ_e typ, input logic run_par);
        logic exp_bit;
        case (typ)
            PAR_EVEN:  exp_bit = run_par;
            PAR_ODD:   exp_bit = ~run_par;
            PAR_MARK:  exp_bit = 1'b1;
            default:   exp_bit = 1'b0;
        endcase
        return exp_bit;
    endfunction

endpackage

// File: rtl/uart_rx_frame_check_if.sv
// Bit-sampler to frame-checker link: strobes towards the checker, the
// decoded word and its flags back towards the consumer.
interface uart_rx_frame_check_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  start_det;
    logic                  bit_strb;
    logic                  sampled_bit;
    logic                  abort;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  data_valid;
    logic                  par_error;
    logic                  stp_error;

    // Sampler side: drives strobes, observes the decoded frame.
    modport master (
        output start_det, bit_strb, sampled_bit, abort,
        input  P_DATA, data_valid, par_error, stp_error
    );

    // Checker side: consumes strobes, produces the decoded frame.
    modport slave (
        input  start_det, bit_strb, sampled_bit, abort,
        output P_DATA, data_valid, par_error, stp_error
    );
endinterface

// File: rtl/uart_rx_frame_check_sat_counter.sv
// Saturating event counter; a clear coinciding with an increment yields 1.
module sat_counter #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] cnt
);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    // Next count: clear first, then apply the increment; hold at the ceiling.
    always_comb begin
        if (clr) begin
            cnt_d = inc ? CNT_WIDTH'(1) : '0;
        end else if (inc && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with <= so every flop samples pre-edge values.
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/uart_rx_frame_check.sv
// Per-frame UART RX checker: deserialises LSB-first data from sampler
// strobes, checks parity and stop bits, presents the word for one cycle
// and keeps saturating parity/stop error counters.
module uart_rx_frame_check
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  PAR_EN,
    input  logic [1:0]            PAR_TYP,
    input  logic                  STOP_2,
    input  logic                  cnt_clr,
    uart_rx_frame_check_if.slave  rx,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  par_err_cnt,
    output logic [CNT_WIDTH-1:0]  stp_err_cnt
);
    localparam int IDX_W = $clog2(DATA_WIDTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    state_e                state_q,       state_d;
    logic                  par_en_q,      par_en_d;
    par_typ_e              par_typ_q,     par_typ_d;
    logic                  stop_2_q,      stop_2_d;
    logic [IDX_W-1:0]      idx_q,         idx_d;
    logic [DATA_WIDTH-1:0] shift_q,       shift_d;
    logic                  run_par_q,     run_par_d;
    logic                  par_err_acc_q, par_err_acc_d;
    logic                  stp_err_acc_q, stp_err_acc_d;
    logic                  stop_cnt_q,    stop_cnt_d;
    logic [DATA_WIDTH-1:0] p_data_q,      p_data_d;
    logic                  data_valid_q,  data_valid_d;
    logic                  par_error_q,   par_error_d;
    logic                  stp_error_q,   stp_error_d;

    logic                  stp_err_now;

    // Next-state, datapath and frame-completion logic.
    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        state_d       = state_q;
        par_en_d      = par_en_q;
        par_typ_d     = par_typ_q;
        stop_2_d      = stop_2_q;
        idx_d         = idx_q;
        shift_d       = shift_q;
        run_par_d     = run_par_q;
        par_err_acc_d = par_err_acc_q;
        stp_err_acc_d = stp_err_acc_q;
        stop_cnt_d    = stop_cnt_q;
        p_data_d      = p_data_q;
        par_error_d   = par_error_q;
        stp_error_d   = stp_error_q;
        data_valid_d  = 1'b0;
        stp_err_now   = stp_err_acc_q | ~rx.sampled_bit;

        if (rx.abort && (state_q != ST_IDLE)) begin
            // Drop the frame; delivered word, flags and counters stay untouched.
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // A strobe coinciding with start_det belongs to the start bit.
                    if (rx.start_det) begin
                        state_d       = ST_DATA;
                        par_en_d      = PAR_EN;
                        par_typ_d     = par_typ_e'(PAR_TYP);
                        stop_2_d      = STOP_2;
                        idx_d         = '0;
                        run_par_d     = 1'b0;
                        par_err_acc_d = 1'b0;
                        stp_err_acc_d = 1'b0;
                        stop_cnt_d    = 1'b0;
                    end
                end
                ST_DATA: begin
                    if (rx.bit_strb) begin
                        shift_d   = {rx.sampled_bit, shift_q[DATA_WIDTH-1:1]};
                        run_par_d = run_par_q ^ rx.sampled_bit;
                        idx_d     = idx_q + IDX_W'(1);
                        if (idx_q == IDX_LAST) begin
                            state_d = par_en_q ? ST_PARITY : ST_STOP;
                        end
                    end
                end
                ST_PARITY: begin
                    if (rx.bit_strb) begin
                        par_err_acc_d = rx.sampled_bit != expected_par_bit(par_typ_q, run_par_q);
                        state_d       = ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (rx.bit_strb) begin
                        if (!stop_2_q || stop_cnt_q) begin
                            state_d      = ST_IDLE;
                            data_valid_d = 1'b1;
                            p_data_d     = shift_q;
                            par_error_d  = par_err_acc_q;
                            stp_error_d  = stp_err_now;
                        end else begin
                            stop_cnt_d    = 1'b1;
                            stp_err_acc_d = stp_err_now;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and datapath registers, all cleared by synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= ST_IDLE;
            par_en_q      <= 1'b0;
            par_typ_q     <= PAR_EVEN;
            stop_2_q      <= 1'b0;
            idx_q         <= '0;
            // NOTE: the shift register is reset too, so P_DATA and debug views start at a known 0.
            shift_q       <= '0;
            run_par_q     <= 1'b0;
            par_err_acc_q <= 1'b0;
            stp_err_acc_q <= 1'b0;
            stop_cnt_q    <= 1'b0;
            p_data_q      <= '0;
            data_valid_q  <= 1'b0;
            par_error_q   <= 1'b0;
            stp_error_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            par_en_q      <= par_en_d;
            par_typ_q     <= par_typ_d;
            stop_2_q      <= stop_2_d;
            idx_q         <= idx_d;
            shift_q       <= shift_d;
            run_par_q     <= run_par_d;
            par_err_acc_q <= par_err_acc_d;
            stp_err_acc_q <= stp_err_acc_d;
            stop_cnt_q    <= stop_cnt_d;
            p_data_q      <= p_data_d;
            data_valid_q  <= data_valid_d;
            par_error_q   <= par_error_d;
            stp_error_q   <= stp_error_d;
        end
    end

    // Error counters advance in the cycle the flagged word is presented.
    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_par_cnt (
        .clk (CLK),
        .rst (RST),
        .inc (data_valid_q & par_error_q),
        .clr (cnt_clr),
        .cnt (par_err_cnt)
    );

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stp_cnt (
        .clk (CLK),
        .rst (RST),
        .inc (data_valid_q & stp_error_q),
        .clr (cnt_clr),
        .cnt (stp_err_cnt)
    );

    assign rx.P_DATA     = p_data_q;
    assign rx.data_valid = data_valid_q;
    assign rx.par_error  = par_error_q;
    assign rx.stp_error  = stp_error_q;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_frame_check.sv
// Scenario bench for uart_rx_frame_check with a frame scoreboard.
module tb_uart_rx_frame_check;
    localparam int DW = 8;
    localparam int CW = 8;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          CLK = 1'b0;
    logic          RST;
    logic          PAR_EN;
    logic [1:0]    PAR_TYP;
    logic          STOP_2;
    logic          cnt_clr;
    logic          busy;
    logic [CW-1:0] par_err_cnt;
    logic [CW-1:0] stp_err_cnt;

    uart_rx_frame_check_if #(.DATA_WIDTH(DW)) rx_if ();

    uart_rx_frame_check #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .PAR_EN      (PAR_EN),
        .PAR_TYP     (PAR_TYP),
        .STOP_2      (STOP_2),
        .cnt_clr     (cnt_clr),
        .rx          (rx_if),
        .busy        (busy),
        .par_err_cnt (par_err_cnt),
        .stp_err_cnt (stp_err_cnt)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] data;
        logic          pe;
        logic          se;
        int            cyc;
    } exp_t;

    exp_t          sb[$];
    int            n_tests = 0;
    int            n_fail  = 0;
    int            par_cnt_m = 0;
    int            stp_cnt_m = 0;
    logic [DW-1:0] last_data = '0;
    logic          last_pe = 1'b0;
    logic          last_se = 1'b0;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic strobe(input logic b);
        rx_if.bit_strb    = 1'b1;
        rx_if.sampled_bit = b;
        tick();
        rx_if.bit_strb    = 1'b0;
        tick();
    endtask

    // Scoreboard monitor and counter model, sampled on the falling edge.
    initial begin
        exp_t e;
        logic inc_p, inc_s;
        forever begin
            @(negedge CLK);
            if (RST) begin
                par_cnt_m = 0;
                stp_cnt_m = 0;
            end else begin
                inc_p = 1'b0;
                inc_s = 1'b0;
                if (rx_if.data_valid === 1'b1) begin
                    n_tests++;
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_data_valid: got P_DATA=%h at cycle %0d, expected no frame", rx_if.P_DATA, cyc);
                    end else begin
                        e = sb.pop_front();
                        inc_p = e.pe;
                        inc_s = e.se;
                        if (rx_if.P_DATA !== e.data) begin
                            n_fail++;
                            $display("FAIL p_data: got %h expected %h", rx_if.P_DATA, e.data);
                        end
                        n_tests++;
                        if (rx_if.par_error !== e.pe) begin
                            n_fail++;
                            $display("FAIL par_error: got %b expected %b (data %h)", rx_if.par_error, e.pe, e.data);
                        end
                        n_tests++;
                        if (rx_if.stp_error !== e.se) begin
                            n_fail++;
                            $display("FAIL stp_error: got %b expected %b (data %h)", rx_if.stp_error, e.se, e.data);
                        end
                        n_tests++;
                        if (cyc != e.cyc) begin
                            n_fail++;
                            $display("FAIL valid_latency: data_valid at cycle %0d expected %0d", cyc, e.cyc);
                        end
                    end
                end
                if (cnt_clr) begin
                    par_cnt_m = inc_p ? 1 : 0;
                    stp_cnt_m = inc_s ? 1 : 0;
                end else begin
                    if (inc_p && par_cnt_m != CNT_MAX) par_cnt_m++;
                    if (inc_s && stp_cnt_m != CNT_MAX) stp_cnt_m++;
                end
            end
        end
    end

    // variant: 0 plain, 1 cnt_clr in data_valid cycle, 2 strobe with start_det,
    // 3 start_det and config toggle in the middle of the data bits.
    task automatic send_frame(input logic [DW-1:0] data, input logic par_bit,
                              input logic s1, input logic s2, input int variant);
        logic       pe, st2, exp_bit, pexp, sexp;
        logic [1:0] pt;
        int         nstop;
        exp_t       e;
        pe  = PAR_EN;
        pt  = PAR_TYP;
        st2 = STOP_2;
        case (pt)
            2'b00:   exp_bit = ^data;
            2'b01:   exp_bit = ~^data;
            2'b10:   exp_bit = 1'b1;
            default: exp_bit = 1'b0;
        endcase
        pexp  = pe && (par_bit != exp_bit);
        sexp  = (s1 == 1'b0) || (st2 && s2 == 1'b0);
        nstop = st2 ? 2 : 1;

        rx_if.start_det = 1'b1;
        if (variant == 2) begin
            rx_if.bit_strb    = 1'b1;
            rx_if.sampled_bit = ~data[0];
        end
        tick();
        rx_if.start_det = 1'b0;
        rx_if.bit_strb  = 1'b0;
        tick();
        for (int i = 0; i < DW; i++) begin
            if (variant == 3 && i == 2) begin
                rx_if.start_det = 1'b1;
                PAR_EN  = ~pe;
                PAR_TYP = ~pt;
                STOP_2  = ~st2;
                tick();
                rx_if.start_det = 1'b0;
            end
            strobe(data[i]);
        end
        if (pe) strobe(par_bit);
        for (int k = 0; k < nstop; k++) begin
            rx_if.bit_strb    = 1'b1;
            rx_if.sampled_bit = (k == 0) ? s1 : s2;
            tick();
            rx_if.bit_strb = 1'b0;
            if (k == nstop - 1) begin
                e.data = data;
                e.pe   = pexp;
                e.se   = sexp;
                e.cyc  = cyc;
                sb.push_back(e);
                last_data = data;
                last_pe   = pexp;
                last_se   = sexp;
                if (variant == 1) cnt_clr = 1'b1;
            end
            tick();
            cnt_clr = 1'b0;
        end
        PAR_EN  = pe;
        PAR_TYP = pt;
        STOP_2  = st2;
        tick();
    endtask

    task automatic test_reset();
        RST = 1'b1;
        PAR_EN = 1'b1; PAR_TYP = 2'b00; STOP_2 = 1'b0; cnt_clr = 1'b0;
        rx_if.start_det = 1'b0; rx_if.bit_strb = 1'b0;
        rx_if.sampled_bit = 1'b1; rx_if.abort = 1'b0;
        tick(); tick();
        n_tests++;
        if ({busy, rx_if.data_valid, rx_if.par_error, rx_if.stp_error} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got busy/dv/pe/se=%b%b%b%b expected 0000",
                     busy, rx_if.data_valid, rx_if.par_error, rx_if.stp_error);
        end
        n_tests++;
        if (rx_if.P_DATA !== '0) begin
            n_fail++;
            $display("FAIL reset_p_data: got %h expected 00", rx_if.P_DATA);
        end
        n_tests++;
        if (par_err_cnt !== '0 || stp_err_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_counters: got %0d/%0d expected 0/0", par_err_cnt, stp_err_cnt);
        end
        RST = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        PAR_EN = 1'b1; PAR_TYP = 2'b00; STOP_2 = 1'b0;
        rx_if.start_det = 1'b1;
        tick();
        rx_if.start_det = 1'b0;
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_after_start: got %b expected 1", busy);
        end
        tick(); tick(); tick();
        // Dummy start above is still open; abort it cleanly before the real frame.
        rx_if.abort = 1'b1; tick(); rx_if.abort = 1'b0; tick();
        send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 0);
        tick();
        n_tests++;
        if (busy !== 1'b0 || rx_if.data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_frame: got busy=%b dv=%b expected 0 0", busy, rx_if.data_valid);
        end
        n_tests++;
        if (rx_if.P_DATA !== 8'hA5) begin
            n_fail++;
            $display("FAIL p_data_hold: got %h expected a5", rx_if.P_DATA);
        end
        send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 0);
    endtask

    task automatic test_parity();
        PAR_TYP = 2'b01;
        send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 0);
        tick();
        n_tests++;
        if (par_err_cnt !== CW'(par_cnt_m) || par_cnt_m != 1) begin
            n_fail++;
            $display("FAIL par_cnt_after_odd: got %0d expected 1 (model %0d)", par_err_cnt, par_cnt_m);
        end
        PAR_TYP = 2'b10;
        send_frame(8'h0F, 1'b0, 1'b1, 1'b1, 0);
        PAR_TYP = 2'b11;
        send_frame(8'h0F, 1'b0, 1'b1, 1'b1, 0);
        tick();
        n_tests++;
        if (par_err_cnt !== CW'(par_cnt_m)) begin
            n_fail++;
            $display("FAIL par_cnt_mark_space: got %0d expected %0d", par_err_cnt, par_cnt_m);
        end
        PAR_TYP = 2'b00;
    endtask

    task automatic test_stop();
        STOP_2 = 1'b1;
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 0);
        send_frame(8'h81, 1'b0, 1'b1, 1'b1, 0);
        tick();
        n_tests++;
        if (stp_err_cnt !== CW'(stp_cnt_m) || stp_cnt_m != 1) begin
            n_fail++;
            $display("FAIL stp_cnt: got %0d expected 1 (model %0d)", stp_err_cnt, stp_cnt_m);
        end
        STOP_2 = 1'b0;
        PAR_EN = 1'b0;
        PAR_TYP = 2'b01;
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 0);
        send_frame(8'h7E, 1'b1, 1'b0, 1'b1, 0);
        PAR_EN = 1'b1;
        PAR_TYP = 2'b00;
    endtask

    task automatic test_abort();
        logic [DW-1:0] d;
        d = 8'hC3;
        rx_if.start_det = 1'b1; tick(); rx_if.start_det = 1'b0; tick();
        for (int i = 0; i < 4; i++) strobe(d[i]);
        rx_if.abort = 1'b1; tick(); rx_if.abort = 1'b0;
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_busy: got %b expected 0", busy);
        end
        for (int i = 0; i < 20; i++) tick();
        n_tests++;
        if (rx_if.P_DATA !== last_data || rx_if.par_error !== last_pe || rx_if.stp_error !== last_se) begin
            n_fail++;
            $display("FAIL abort_hold: got %h/%b/%b expected %h/%b/%b", rx_if.P_DATA,
                     rx_if.par_error, rx_if.stp_error, last_data, last_pe, last_se);
        end
        rx_if.abort = 1'b1; tick(); rx_if.abort = 1'b0;
        send_frame(8'h5A, 1'b0, 1'b1, 1'b1, 0);
    endtask

    task automatic test_saturation();
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0; tick();
        n_tests++;
        if (par_err_cnt !== '0 || stp_err_cnt !== '0 || par_cnt_m != 0) begin
            n_fail++;
            $display("FAIL cnt_clr_alone: got %0d/%0d expected 0/0", par_err_cnt, stp_err_cnt);
        end
        for (int i = 0; i < CNT_MAX + 1; i++) send_frame(8'(i), ~(^8'(i)), 1'b1, 1'b1, 0);
        tick();
        n_tests++;
        if (par_err_cnt !== CW'(CNT_MAX) || par_cnt_m != CNT_MAX) begin
            n_fail++;
            $display("FAIL par_cnt_saturate: got %0d expected %0d", par_err_cnt, CNT_MAX);
        end
        send_frame(8'h11, 1'b1, 1'b1, 1'b1, 1);
        tick();
        n_tests++;
        if (par_err_cnt !== CW'(1) || par_cnt_m != 1) begin
            n_fail++;
            $display("FAIL clr_with_inc: got %0d expected 1", par_err_cnt);
        end
    endtask

    task automatic test_edge();
        send_frame(8'h96, 1'b0, 1'b1, 1'b1, 2);
        send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 3);
        rx_if.start_det = 1'b1; tick(); rx_if.start_det = 1'b0; tick();
        strobe(1'b1); strobe(1'b0); strobe(1'b1);
        RST = 1'b1; tick(); RST = 1'b0;
        n_tests++;
        if ({busy, rx_if.data_valid, rx_if.par_error, rx_if.stp_error} !== 4'b0000 ||
            rx_if.P_DATA !== '0) begin
            n_fail++;
            $display("FAIL rst_midframe_outputs: got busy=%b dv=%b pe=%b se=%b data=%h expected all 0",
                     busy, rx_if.data_valid, rx_if.par_error, rx_if.stp_error, rx_if.P_DATA);
        end
        n_tests++;
        if (par_err_cnt !== '0 || stp_err_cnt !== '0) begin
            n_fail++;
            $display("FAIL rst_midframe_counters: got %0d/%0d expected 0/0", par_err_cnt, stp_err_cnt);
        end
        last_data = '0; last_pe = 1'b0; last_se = 1'b0;
        tick();
        send_frame(8'hE7, 1'b1, 1'b1, 1'b1, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_stop();
        test_abort();
        test_saturation();
        test_edge();
        for (int i = 0; i < 10; i++) tick();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL missing_frames: %0d expected frames never delivered, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
